// File: rtl/garage_gate_arbiter_if.sv
// rtl/garage_gate_arbiter_if.sv - lane sensor / occupancy counter bundle for the garage gate arbiter
interface garage_gate_arbiter_if #(
  parameter int CNT_W = 6
);
  logic             entry_req;
  logic             exit_req;
  logic             pass_sensor;
  logic [CNT_W-1:0] car_count;
  logic             gate_open;
  logic             entry_grant;
  logic             exit_grant;
  logic             cnt_inc;
  logic             cnt_dec;
  logic             entry_denied;
  logic             timeout_evt;
  logic [1:0]       state;

  modport master (
    output entry_req, exit_req, pass_sensor, car_count,
    input  gate_open, entry_grant, exit_grant, cnt_inc, cnt_dec,
           entry_denied, timeout_evt, state
  );

  modport slave (
    input  entry_req, exit_req, pass_sensor, car_count,
    output gate_open, entry_grant, exit_grant, cnt_inc, cnt_dec,
           entry_denied, timeout_evt, state
  );
endinterface

// File: rtl/garage_gate_arbiter.sv
// rtl/garage_gate_arbiter.sv - shared entry/exit barrier arbiter; GATE_FAIR_RR_EN selects round-robin over exit-priority
module garage_gate_arbiter #(
  parameter int MAX_CARS     = 50,
  parameter int CNT_W        = 6,
  parameter int PASS_TIMEOUT = 32,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  garage_gate_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2,
    GUARD    = 2'd3
  } state_t;

  localparam int WAIT_W = $clog2(PASS_TIMEOUT + 1);
  localparam int GRD_W  = $clog2(GUARD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_CARS);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PASS_TIMEOUT - 1);
  localparam logic [GRD_W-1:0]  GRD_LAST  = GRD_W'(GUARD_CYCLES - 1);

  state_t            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [GRD_W-1:0]  guard_q;
  logic              last_served_q;
  logic              gate_open_q;
  logic              entry_grant_q;
  logic              exit_grant_q;
  logic              cnt_inc_q;
  logic              cnt_dec_q;
  logic              entry_denied_q;
  logic              timeout_evt_q;

  logic entry_ok;
  logic exit_ok;
  logic serve_exit;

  assign entry_ok = bus.entry_req && (bus.car_count < MAX_C);
  assign exit_ok  = bus.exit_req && (bus.car_count != '0);

`ifdef GATE_FAIR_RR_EN
  // Under contention, hand the gate to whichever side did not go last.
  assign serve_exit = exit_ok && (!entry_ok || !last_served_q);
`else
  assign serve_exit = exit_ok;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wait_q         <= '0;
      guard_q        <= '0;
      last_served_q  <= 1'b0;
      gate_open_q    <= 1'b0;
      entry_grant_q  <= 1'b0;
      exit_grant_q   <= 1'b0;
      cnt_inc_q      <= 1'b0;
      cnt_dec_q      <= 1'b0;
      entry_denied_q <= 1'b0;
      timeout_evt_q  <= 1'b0;
    end else begin
      cnt_inc_q      <= 1'b0;
      cnt_dec_q      <= 1'b0;
      timeout_evt_q  <= 1'b0;
      entry_denied_q <= 1'b0;
      case (state_q)
        IDLE: begin
          entry_denied_q <= bus.entry_req && (bus.car_count >= MAX_C);
          wait_q         <= '0;
          if (serve_exit) begin
            state_q       <= OPEN_OUT;
            gate_open_q   <= 1'b1;
            exit_grant_q  <= 1'b1;
            last_served_q <= 1'b1;
          end else if (entry_ok) begin
            state_q       <= OPEN_IN;
            gate_open_q   <= 1'b1;
            entry_grant_q <= 1'b1;
            last_served_q <= 1'b0;
          end else begin
            last_served_q <= last_served_q;
          end
        end
        OPEN_IN, OPEN_OUT: begin
          // A pass on the final wait cycle still counts the car.
          if (bus.pass_sensor || (wait_q == WAIT_LAST)) begin
            state_q       <= GUARD;
            guard_q       <= '0;
            gate_open_q   <= 1'b0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            cnt_inc_q     <= bus.pass_sensor && (state_q == OPEN_IN);
            cnt_dec_q     <= bus.pass_sensor && (state_q == OPEN_OUT);
            timeout_evt_q <= !bus.pass_sensor;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        GUARD: begin
          if (guard_q == GRD_LAST) begin
            state_q <= IDLE;
          end else begin
            guard_q <= guard_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.gate_open    = gate_open_q;
  assign bus.entry_grant  = entry_grant_q;
  assign bus.exit_grant   = exit_grant_q;
  assign bus.cnt_inc      = cnt_inc_q;
  assign bus.cnt_dec      = cnt_dec_q;
  assign bus.entry_denied = entry_denied_q;
  assign bus.timeout_evt  = timeout_evt_q;

endmodule

// File: tb/tb_garage_gate_arbiter.sv
// tb/tb_garage_gate_arbiter.sv - randomized bench for garage_gate_arbiter against a timeline reference model
module tb_garage_gate_arbiter;
  localparam int MAX_CARS     = 50;
  localparam int CNT_W        = 6;
  localparam int PASS_TIMEOUT = 32;
  localparam int GUARD_CYCLES = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  garage_gate_arbiter_if #(.CNT_W(CNT_W)) bus();

  garage_gate_arbiter #(
    .MAX_CARS(MAX_CARS), .CNT_W(CNT_W),
    .PASS_TIMEOUT(PASS_TIMEOUT), .GUARD_CYCLES(GUARD_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: phase 0 idle, 1 in, 2 out, 3 guard; deadlines kept as absolute edge numbers.
  int cyc = 0;
  int m_ph = 0;
  int m_abort_at = 0;
  int m_guard_end = 0;
  bit m_last = 1'b0;

  task automatic drive(input bit en, input bit ex, input bit ps, input int cnt, input bit r);
    bus.entry_req   = en;
    bus.exit_req    = ex;
    bus.pass_sensor = ps;
    bus.car_count   = CNT_W'(cnt);
    reset           = r;
  endtask

  task automatic step();
    bit en, ex, ps, r, eo, xo, want_exit;
    bit e_inc, e_dec, e_to, e_den;
    int cnt;
    en = bus.entry_req; ex = bus.exit_req; ps = bus.pass_sensor; r = reset;
    cnt = int'(bus.car_count);
    @(posedge clk);
    cyc++;
    e_inc = 0; e_dec = 0; e_to = 0; e_den = 0;
    if (r) begin
      m_ph = 0;
      m_last = 0;
    end else if (m_ph == 0) begin
      e_den = en && (cnt >= MAX_CARS);
      eo = en && (cnt < MAX_CARS);
      xo = ex && (cnt != 0);
      if (eo || xo) begin
        if (eo && xo) begin
`ifdef GATE_FAIR_RR_EN
          want_exit = (m_last == 1'b0);
`else
          want_exit = 1'b1;
`endif
        end else begin
          want_exit = xo;
        end
        m_ph = want_exit ? 2 : 1;
        m_last = want_exit;
        m_abort_at = cyc + PASS_TIMEOUT;
      end
    end else if (m_ph == 1 || m_ph == 2) begin
      if (ps) begin
        if (m_ph == 1) e_inc = 1; else e_dec = 1;
        m_ph = 3;
        m_guard_end = cyc + GUARD_CYCLES;
      end else if (cyc == m_abort_at) begin
        e_to = 1;
        m_ph = 3;
        m_guard_end = cyc + GUARD_CYCLES;
      end
    end else begin
      if (cyc == m_guard_end) m_ph = 0;
    end
    #1;
    check("state",        bus.state,        m_ph);
    check("gate_open",    bus.gate_open,    int'(m_ph == 1 || m_ph == 2));
    check("entry_grant",  bus.entry_grant,  int'(m_ph == 1));
    check("exit_grant",   bus.exit_grant,   int'(m_ph == 2));
    check("cnt_inc",      bus.cnt_inc,      int'(e_inc));
    check("cnt_dec",      bus.cnt_dec,      int'(e_dec));
    check("entry_denied", bus.entry_denied, int'(e_den));
    check("timeout_evt",  bus.timeout_evt,  int'(e_to));
  endtask

  task automatic repeat_step(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int cnt_tbl[8] = '{0, 1, 10, 20, 49, 50, 51, 63};

  initial begin
    drive(0, 0, 0, 0, 1);
    repeat_step(2);

    drive(1, 0, 0, 10, 0);
    repeat_step(4);
    drive(1, 0, 1, 10, 0);
    step();
    drive(0, 0, 0, 10, 0);
    repeat_step(6);

    drive(1, 0, 0, 50, 0);
    repeat_step(3);
    drive(1, 1, 0, 50, 0);
    repeat_step(3);
    drive(1, 1, 1, 50, 0);
    step();
    drive(0, 0, 0, 49, 0);
    repeat_step(6);

    drive(0, 1, 0, 0, 0);
    repeat_step(5);

    drive(1, 0, 0, 10, 0);
    repeat_step(PASS_TIMEOUT + 8);

    drive(0, 0, 0, 20, 1);
    step();
    drive(1, 1, 1, 20, 0);
    repeat_step(4 * (2 + GUARD_CYCLES) + 2);

    drive(0, 0, 0, 20, 1);
    step();
    drive(0, 1, 0, 20, 0);
    repeat_step(2);
    drive(0, 1, 1, 20, 1);
    step();
    drive(0, 0, 0, 20, 0);
    repeat_step(3);

    for (int seg = 0; seg < 120; seg++) begin
      int len, cnt, pmode;
      len = $urandom_range(8, 80);
      cnt = ($urandom % 8 == 0) ? int'($urandom % 64) : cnt_tbl[$urandom % 8];
      pmode = $urandom % 3;
      for (int i = 0; i < len; i++) begin
        bit ps;
        ps = (pmode == 0) ? 1'b0 : (pmode == 1) ? ($urandom % 10 == 0) : ($urandom % 2 == 0);
        drive($urandom % 4 != 0, $urandom % 3 == 0, ps, cnt, $urandom % 400 == 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
